// File: rtl/word_serializer_pkg.sv
// Shared definitions for the word serializer: FSM encodings used on the serial path.
package word_serializer_pkg;

  // One-hot, 2-bit encodings shared with the other serial-path blocks
  typedef enum logic [1:0] {
    S_IDLE  = 2'b01,
    S_SHIFT = 2'b10
  } state_e;

endpackage

// File: rtl/word_serializer_sync_fifo.sv
// Synchronous FIFO with flush; pointers wrap naturally, count is one bit wider.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == LW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Full FIFO never accepts, even when a pop frees a slot this cycle
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial feeder: buffers words in a FIFO and emits one bit per cycle,
// chaining words without bubbles; hold_i stalls, flush_i drops everything pending.
module word_serializer
  import word_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   hold_i,
  input  logic                   flush_i,
  output logic                   d_o,
  output logic                   valid_o,
  output logic                   busy_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [BW-1:0]    bitcnt_q;
  logic             d_q, valid_q;

  logic [WIDTH-1:0] fifo_dout;
  logic             fifo_full, fifo_empty;
  logic             push, pop;
  logic             lead_bit;
  logic [WIDTH-1:0] shreg_shifted;
  logic             last_bit;

  assign ready_o = ~fifo_full;
  assign push    = valid_i & ready_o;

  assign lead_bit      = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
  assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg_q[WIDTH-1:1]};
  assign last_bit      = (state_q == S_SHIFT) && (bitcnt_q == LAST);

  // Pop on idle start or while the last bit of the current word goes out
  assign pop = ~flush_i & ~hold_i & ~fifo_empty & ((state_q == S_IDLE) | last_bit);

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush_i),
    .data_i  (data_i),
    .data_o  (fifo_dout),
    .level_o (level_o),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      d_q      <= 1'b0;
      valid_q  <= 1'b0;
    end else if (flush_i) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      d_q      <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          valid_q <= 1'b0;
          if (pop) begin
            shreg_q  <= fifo_dout;
            bitcnt_q <= '0;
            state_q  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (hold_i) begin
            valid_q <= 1'b0;
          end else begin
            d_q     <= lead_bit;
            valid_q <= 1'b1;
            if (bitcnt_q == LAST) begin
              bitcnt_q <= '0;
              if (pop) shreg_q <= fifo_dout;
              else begin
                shreg_q <= '0;
                state_q <= S_IDLE;
              end
            end else begin
              shreg_q  <= shreg_shifted;
              bitcnt_q <= bitcnt_q + 1'b1;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign d_o     = d_q;
  assign valid_o = valid_q;
  assign busy_o  = (state_q == S_SHIFT) || (level_o != '0);

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench: MSB-first and LSB-first instances share one stimulus stream.
module tb_word_serializer;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data;
  logic       vld, hold, flush;

  logic       rdy_m, d_m, vo_m, busy_m;
  logic [2:0] lvl_m;
  logic       rdy_l, d_l, vo_l, busy_l;
  logic [2:0] lvl_l;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  logic mq[$];
  logic lq[$];
  int   mc[$];

  always #5 clk = ~clk;

  word_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data), .valid_i(vld), .ready_o(rdy_m),
    .hold_i(hold), .flush_i(flush), .d_o(d_m), .valid_o(vo_m), .busy_o(busy_m),
    .level_o(lvl_m));

  word_serializer #(.WIDTH(8), .DEPTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data), .valid_i(vld), .ready_o(rdy_l),
    .hold_i(hold), .flush_i(flush), .d_o(d_l), .valid_o(vo_l), .busy_o(busy_l),
    .level_o(lvl_l));

  // Serial capture on the falling edge, away from the active edge
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (vo_m) begin mq.push_back(d_m); mc.push_back(cyc); end
    if (vo_l) lq.push_back(d_l);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy_m && n < 300) begin tick(); n++; end
    chk(tag, 64'(busy_m), 64'd0);
    tick(); tick();
  endtask

  initial begin
    logic [7:0]  e;
    logic [47:0] got48, gotl48;
    logic [15:0] vv;
    logic [7:0]  words [6];
    logic [7:0]  g8;
    int s, sl, idx, n, bad;
    bit acc, saw_full;

    words[0] = 8'hD8; words[1] = 8'h1B; words[2] = 8'hFF;
    words[3] = 8'h00; words[4] = 8'hA5; words[5] = 8'h3C;

    rst_n = 1'b0; data = '0; vld = 1'b0; hold = 1'b0; flush = 1'b0;
    #1;
    chk("rst_ready", 64'(rdy_m), 64'd1);
    chk("rst_valid", 64'(vo_m), 64'd0);
    chk("rst_d",     64'(d_m), 64'd0);
    chk("rst_busy",  64'(busy_m), 64'd0);
    chk("rst_level", 64'(lvl_m), 64'd0);
    #20 rst_n = 1'b1;
    tick(); tick();

    // Single word, both bit orders
    e = 8'hD8;
    vld = 1'b1; data = 8'hD8;
    tick();
    vld = 1'b0;
    chk("single_lvl_e0", 64'(lvl_m), 64'd1);
    tick();
    chk("single_lvl_e1", 64'(lvl_m), 64'd0);
    chk("single_vo_e1",  64'(vo_m), 64'd0);
    chk("single_busy_e1", 64'(busy_m), 64'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("single_vo_b%0d", i), 64'(vo_m), 64'd1);
      chk($sformatf("msb_d_b%0d", i), 64'(d_m), 64'(e[7-i]));
      chk($sformatf("lsb_d_b%0d", i), 64'(d_l), 64'(e[i]));
    end
    tick();
    chk("single_vo_end",   64'(vo_m), 64'd0);
    chk("single_busy_end", 64'(busy_m), 64'd0);
    chk("single_lvl_end",  64'(lvl_m), 64'd0);
    tick();

    // Back-to-back burst that fills the FIFO
    s = mq.size(); sl = lq.size();
    idx = 0; n = 0; bad = 0; saw_full = 0;
    while (idx < 6 && n < 100) begin
      vld = 1'b1; data = words[idx];
      acc = rdy_m;
      tick(); n++;
      if (acc) idx++;
      if (rdy_m !== (lvl_m != 3'd4)) bad++;
      if (lvl_m == 3'd4) saw_full = 1;
    end
    vld = 1'b0;
    chk("burst_pushed", 64'(idx), 64'd6);
    chk("burst_ready_vs_level", 64'(bad), 64'd0);
    chk("burst_reached_full", 64'(saw_full), 64'd1);
    wait_idle("burst_drain");
    chk("burst_nbits", 64'(mq.size() - s), 64'd48);
    got48 = '0; gotl48 = '0;
    for (int i = 0; i < 48; i++) begin
      if (s + i < mq.size())  got48[47-i]  = mq[s+i];
      if (sl + i < lq.size()) gotl48[47-i] = lq[sl+i];
    end
    chk("burst_msb_stream", 64'(got48), 64'h0000_D81B_FF00_A53C);
    chk("burst_lsb_stream", 64'(gotl48), 64'h0000_1BD8_FF00_A53C);
    if (mq.size() >= s + 48)
      chk("burst_contiguous", 64'(mc[s+47] - mc[s]), 64'd47);

    // Hold for cycles 5 and 6 while shifting 0xD8
    s = mq.size();
    vld = 1'b1; data = 8'hD8;
    tick();
    vld = 1'b0;
    vv = '0;
    for (int k = 1; k <= 12; k++) begin
      hold = (k == 5 || k == 6);
      tick();
      vv[k] = vo_m;
    end
    hold = 1'b0;
    chk("hold_valid_pattern", 64'(vv), 64'h0F9C);
    g8 = '0;
    for (int i = 0; i < 8; i++) if (s + i < mq.size()) g8[7-i] = mq[s+i];
    chk("hold_nbits", 64'(mq.size() - s), 64'd8);
    chk("hold_bits", 64'(g8), 64'hD8);
    wait_idle("hold_drain");

    // Flush after 3 bits with two words queued; a push in the flush cycle is dropped
    vld = 1'b1; data = 8'hD8; tick();
    data = 8'h1B; tick();
    data = 8'hFF; tick();
    vld = 1'b0;
    tick(); tick();
    chk("flush_pre_lvl", 64'(lvl_m), 64'd2);
    flush = 1'b1; vld = 1'b1; data = 8'hAA;
    tick();
    flush = 1'b0; vld = 1'b0;
    chk("flush_vo",   64'(vo_m), 64'd0);
    chk("flush_lvl",  64'(lvl_m), 64'd0);
    chk("flush_d",    64'(d_m), 64'd0);
    chk("flush_busy", 64'(busy_m), 64'd0);
    s = mq.size();
    vld = 1'b1; data = 8'h1B; tick();
    vld = 1'b0;
    wait_idle("flush_drain");
    g8 = '0;
    for (int i = 0; i < 8; i++) if (s + i < mq.size()) g8[7-i] = mq[s+i];
    chk("flush_nbits", 64'(mq.size() - s), 64'd8);
    chk("flush_bits", 64'(g8), 64'h1B);

    // Asynchronous reset mid-word
    vld = 1'b1; data = 8'hD8; tick();
    data = 8'h3C; tick();
    vld = 1'b0;
    tick(); tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vo",    64'(vo_m), 64'd0);
    chk("arst_d",     64'(d_m), 64'd0);
    chk("arst_busy",  64'(busy_m), 64'd0);
    chk("arst_lvl",   64'(lvl_m), 64'd0);
    chk("arst_ready", 64'(rdy_m), 64'd1);
    vld = 1'b1; data = 8'hFF;
    tick(); tick();
    chk("arst_push_ignored", 64'(lvl_m), 64'd0);
    vld = 1'b0;
    #3 rst_n = 1'b1;
    s = mq.size();
    for (int i = 0; i < 12; i++) tick();
    chk("arst_no_stale", 64'(mq.size() - s), 64'd0);
    chk("arst_ready_after", 64'(rdy_m), 64'd1);
    chk("arst_lvl_after", 64'(lvl_m), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
